// File: rtl/debug_rd_arbiter.sv
// rtl/debug_rd_arbiter.sv - round-robin burst scheduler sharing one 32-bit host pipe-out across debug FIFOs
// Each grant delivers a header word followed by BEATS data words from one channel.
module debug_rd_arbiter #(
  parameter int          NCH      = 4,
  parameter int          BEATS    = 8,
  parameter logic [31:0] PAD_WORD = 32'hFFFF_FFFF
) (
  input  logic              rd_clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [NCH-1:0]    ch_empty,
  input  logic [NCH*32-1:0] ch_dout,
  input  logic [NCH-1:0]    ch_prog_full,
  output logic [NCH-1:0]    ch_rd_en,
  input  logic              host_rd_en,
  output logic [31:0]       host_dout,
  output logic              host_dout_vld,
  output logic              data_avail,
  output logic              any_prog_full,
  output logic              busy,
  output logic [3:0]        grant_id,
  output logic              underrun,
  input  logic              clr_err
);

  localparam int            CW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]    LAST_CH   = 4'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t        state_q;
  logic [BW-1:0] beat_cnt_q;
  logic [3:0]    grant_q;     // doubles as last_grant: both always hold the same value
  logic [15:0]   seq_q [NCH];
  logic          underrun_q;
  logic          data_avail_q;
  logic          any_pf_q;

  logic          sel_found_d;
  logic [3:0]    sel_id_d;
  logic [CW-1:0] gidx;
  logic          g_empty;
  logic [31:0]   g_dout;

  function automatic logic [CW-1:0] rr_idx(input logic [3:0] base, input int k);
    return CW'((int'(base) + k) % NCH);
  endfunction

  assign gidx    = grant_q[CW-1:0];
  assign g_empty = ch_empty[gidx];
  assign g_dout  = ch_dout[32*int'(gidx) +: 32];

  // Scan from farthest to nearest so the nearest non-empty channel after last_grant wins.
  always_comb begin
    sel_found_d = 1'b0;
    sel_id_d    = grant_q;
    for (int k = NCH; k >= 1; k--) begin
      if (!ch_empty[rr_idx(grant_q, k)]) begin
        sel_found_d = 1'b1;
        sel_id_d    = 4'(rr_idx(grant_q, k));
      end
    end
  end

  always_comb begin
    host_dout     = PAD_WORD;
    host_dout_vld = 1'b0;
    ch_rd_en      = '0;
    case (state_q)
      S_HDR: begin
        host_dout     = {8'hA5, grant_q, 4'h0, seq_q[gidx]};
        host_dout_vld = 1'b1;
      end
      S_DATA: begin
        if (!g_empty) begin
          host_dout      = g_dout;
          host_dout_vld  = 1'b1;
          ch_rd_en[gidx] = host_rd_en;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      grant_q      <= LAST_CH;
      underrun_q   <= 1'b0;
      data_avail_q <= 1'b0;
      any_pf_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) seq_q[i] <= '0;
    end else begin
      data_avail_q <= |(~ch_empty);
      any_pf_q     <= |ch_prog_full;
      if (clr_err) underrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && sel_found_d) begin
            grant_q <= sel_id_d;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (host_rd_en) begin
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (host_rd_en) begin
            // An empty beat is still consumed so the burst length stays fixed.
            if (g_empty) underrun_q <= 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              seq_q[gidx] <= seq_q[gidx] + 16'd1;
              beat_cnt_q  <= '0;
              state_q     <= S_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_avail    = data_avail_q;
  assign any_prog_full = any_pf_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_debug_rd_arbiter.sv
// tb/tb_debug_rd_arbiter.sv - directed self-checking bench for debug_rd_arbiter
// Channel FIFOs are modelled as word counters; data word = {tag, remaining-1}.
module tb_debug_rd_arbiter;

  localparam int          NCH = 4;
  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic              clk;
  logic              rstn;
  logic              enable;
  logic [NCH-1:0]    ch_empty;
  logic [NCH*32-1:0] ch_dout;
  logic [NCH-1:0]    ch_prog_full;
  logic [NCH-1:0]    ch_rd_en;
  logic              host_rd_en;
  logic [31:0]       host_dout;
  logic              host_dout_vld;
  logic              data_avail;
  logic              any_prog_full;
  logic              busy;
  logic [3:0]        grant_id;
  logic              underrun;
  logic              clr_err;

  int          avail [NCH] = '{0, 0, 0, 0};
  int          pops  [NCH] = '{0, 0, 0, 0};
  logic [15:0] tag   [NCH] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [NCH-1:0] force_empty;

  int n_tests = 0;
  int n_fail  = 0;

  debug_rd_arbiter #(.NCH(NCH), .BEATS(8), .PAD_WORD(PAD)) dut (
    .rd_clk(clk), .rstn(rstn), .enable(enable), .ch_empty(ch_empty),
    .ch_dout(ch_dout), .ch_prog_full(ch_prog_full), .ch_rd_en(ch_rd_en),
    .host_rd_en(host_rd_en), .host_dout(host_dout), .host_dout_vld(host_dout_vld),
    .data_avail(data_avail), .any_prog_full(any_prog_full), .busy(busy),
    .grant_id(grant_id), .underrun(underrun), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ch_empty = '0;
    ch_dout  = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i]          = ((avail[i] - pops[i]) <= 0) || force_empty[i];
      ch_dout[i*32 +: 32]  = {tag[i], 16'(avail[i] - pops[i] - 1)};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (ch_rd_en[i]) pops[i] <= pops[i] + 1;
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (host_dout !== PAD) begin n_fail++; $display("FAIL rst_dout got %h want %h", host_dout, PAD); end
    n_tests++; if (host_dout_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b want 0", host_dout_vld); end
    n_tests++; if (ch_rd_en !== 4'b0) begin n_fail++; $display("FAIL rst_rd_en got %b want 0000", ch_rd_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++; if (grant_id !== 4'd3) begin n_fail++; $display("FAIL rst_grant got %0d want 3", grant_id); end
    n_tests++; if ({underrun, data_avail, any_prog_full} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {underrun, data_avail, any_prog_full}); end
  endtask

  task automatic test_single_burst;
    int p0;
    @(negedge clk);
    rstn = 1'b1; p0 = pops[2]; avail[2] = avail[2] + 8; enable = 1'b1; host_rd_en = 1'b1;
    #1;
    n_tests++; if (host_dout !== PAD || host_dout_vld !== 1'b0) begin n_fail++; $display("FAIL sb_idle got %h/%b want %h/0", host_dout, host_dout_vld, PAD); end
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA520_0000 || host_dout_vld !== 1'b1) begin n_fail++; $display("FAIL sb_hdr got %h/%b want a5200000/1", host_dout, host_dout_vld); end
    n_tests++; if (grant_id !== 4'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL sb_grant got %0d/%b want 2/1", grant_id, busy); end
    n_tests++; if (data_avail !== 1'b1) begin n_fail++; $display("FAIL sb_avail got %b want 1", data_avail); end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); #1;
      n_tests++; if (host_dout !== 32'(7 - b) || host_dout_vld !== 1'b1) begin n_fail++; $display("FAIL sb_beat%0d got %h/%b want %h/1", b, host_dout, host_dout_vld, 32'(7 - b)); end
      n_tests++; if (ch_rd_en !== 4'b0100) begin n_fail++; $display("FAIL sb_pop%0d got %b want 0100", b, ch_rd_en); end
    end
    @(negedge clk);
    avail[2] = avail[2] + 8;
    #1;
    n_tests++; if (host_dout !== PAD || host_dout_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sb_gap got %h/%b/%b want pad/0/0", host_dout, host_dout_vld, busy); end
    n_tests++; if (pops[2] - p0 !== 8) begin n_fail++; $display("FAIL sb_popcnt got %0d want 8", pops[2] - p0); end
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA520_0001) begin n_fail++; $display("FAIL sb_seq got %h want a5200001", host_dout); end
    repeat (9) @(negedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sb_end got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    int p [NCH];
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      p[i] = pops[i];
      avail[i] = avail[i] + ((i == 0) ? 16 : 8);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (host_dout_vld !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d got %b want 0", k, host_dout_vld); end
      @(negedge clk); #1;
      n_tests++; if (host_dout !== {8'hA5, 4'(k % 4), 4'h0, 16'(k / 4)}) begin n_fail++; $display("FAIL rr_hdr%0d got %h want %h", k, host_dout, {8'hA5, 4'(k % 4), 4'h0, 16'(k / 4)}); end
      n_tests++; if (grant_id !== 4'(k % 4)) begin n_fail++; $display("FAIL rr_grant%0d got %0d want %0d", k, grant_id, k % 4); end
      repeat (9) @(negedge clk);
      #1;
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_end got %b want 0", busy); end
    n_tests++; if (pops[0] - p[0] !== 16 || pops[3] - p[3] !== 8) begin n_fail++; $display("FAIL rr_pops got %0d/%0d want 16/8", pops[0] - p[0], pops[3] - p[3]); end
  endtask

  task automatic test_stall;
    int p0;
    @(negedge clk);
    tag[1] = 16'h00C1; p0 = pops[1]; avail[1] = avail[1] + 8; host_rd_en = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA510_0001) begin n_fail++; $display("FAIL st_hdr got %h want a5100001", host_dout); end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      host_rd_en = 1'b0;
      #1;
      n_tests++; if (host_dout !== 32'h00C1_0004 || ch_rd_en !== 4'b0) begin n_fail++; $display("FAIL st_hold%0d got %h/%b want 00c10004/0000", s, host_dout, ch_rd_en); end
    end
    @(negedge clk);
    host_rd_en = 1'b1;
    #1;
    n_tests++; if (host_dout !== 32'h00C1_0004 || ch_rd_en !== 4'b0010) begin n_fail++; $display("FAIL st_resume got %h/%b want 00c10004/0010", host_dout, ch_rd_en); end
    repeat (4) @(negedge clk);
    @(negedge clk); #1;
    n_tests++; if (pops[1] - p0 !== 8 || busy !== 1'b0) begin n_fail++; $display("FAIL st_pops got %0d/%b want 8/0", pops[1] - p0, busy); end
  endtask

  task automatic test_underrun;
    int p0;
    @(negedge clk);
    p0 = pops[1]; avail[1] = avail[1] + 8;
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA510_0002) begin n_fail++; $display("FAIL ur_hdr got %h want a5100002", host_dout); end
    repeat (5) @(negedge clk);
    #1;
    n_tests++; if (host_dout_vld !== 1'b1 || underrun !== 1'b0) begin n_fail++; $display("FAIL ur_beat4 got %b/%b want 1/0", host_dout_vld, underrun); end
    @(negedge clk);
    force_empty[1] = 1'b1; clr_err = 1'b1;
    #1;
    n_tests++; if (host_dout !== PAD || host_dout_vld !== 1'b0 || ch_rd_en !== 4'b0) begin n_fail++; $display("FAIL ur_beat5 got %h/%b/%b want pad/0/0000", host_dout, host_dout_vld, ch_rd_en); end
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_prio got %b want 1", underrun); end
    @(negedge clk); #1;
    n_tests++; if (host_dout_vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ur_beat7 got %b/%b want 0/1", host_dout_vld, busy); end
    @(negedge clk); #1;
    n_tests++; if (pops[1] - p0 !== 5 || busy !== 1'b0 || underrun !== 1'b1) begin n_fail++; $display("FAIL ur_end got %0d/%b/%b want 5/0/1", pops[1] - p0, busy, underrun); end
    avail[1] = pops[1]; force_empty[1] = 1'b0; clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clr got %b want 0", underrun); end
  endtask

  task automatic test_enable_drop;
    int p3;
    @(negedge clk);
    p3 = pops[3]; avail[3] = avail[3] + 8; avail[0] = avail[0] + 8; host_rd_en = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA530_0001 || grant_id !== 4'd3) begin n_fail++; $display("FAIL en_hdr got %h/%0d want a5300001/3", host_dout, grant_id); end
    enable = 1'b0; host_rd_en = 1'b1;
    repeat (9) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (host_dout !== PAD || busy !== 1'b0) begin n_fail++; $display("FAIL en_idle%0d got %h/%b want pad/0", c, host_dout, busy); end
      @(negedge clk);
    end
    n_tests++; if (pops[3] - p3 !== 8) begin n_fail++; $display("FAIL en_pops got %0d want 8", pops[3] - p3); end
    enable = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA500_0002 || grant_id !== 4'd0) begin n_fail++; $display("FAIL en_resume got %h/%0d want a5000002/0", host_dout, grant_id); end
    repeat (9) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int p2;
    @(negedge clk);
    p2 = pops[2]; avail[2] = avail[2] + 8;
    @(negedge clk); #1;
    n_tests++; if (grant_id !== 4'd2) begin n_fail++; $display("FAIL rm_grant got %0d want 2", grant_id); end
    repeat (4) @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_tests++; if (ch_rd_en !== 4'b0 || host_dout !== PAD || host_dout_vld !== 1'b0) begin n_fail++; $display("FAIL rm_out got %b/%h/%b want 0000/pad/0", ch_rd_en, host_dout, host_dout_vld); end
    @(negedge clk);
    avail[0] = avail[0] + 8; rstn = 1'b1;
    #1;
    n_tests++; if (pops[2] - p2 !== 4) begin n_fail++; $display("FAIL rm_pops got %0d want 4", pops[2] - p2); end
    @(negedge clk); #1;
    n_tests++; if (host_dout !== 32'hA500_0000 || grant_id !== 4'd0) begin n_fail++; $display("FAIL rm_first got %h/%0d want a5000000/0", host_dout, grant_id); end
  endtask

  task automatic test_status;
    @(negedge clk);
    ch_prog_full = 4'b0100;
    #1;
    n_tests++; if (any_prog_full !== 1'b0) begin n_fail++; $display("FAIL pf_early got %b want 0", any_prog_full); end
    @(negedge clk);
    ch_prog_full = 4'b0000;
    #1;
    n_tests++; if (any_prog_full !== 1'b1) begin n_fail++; $display("FAIL pf_set got %b want 1", any_prog_full); end
    @(negedge clk); #1;
    n_tests++; if (any_prog_full !== 1'b0) begin n_fail++; $display("FAIL pf_clr got %b want 0", any_prog_full); end
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; host_rd_en = 1'b0; clr_err = 1'b0;
    ch_prog_full = '0; force_empty = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    test_status();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
